// File: rtl/round_poly_engine_pkg.sv
// Shared constants, FSM encoding and helpers for the streaming Round() engine.
package round_poly_engine_pkg;

   localparam int unsigned W     = 13;
   localparam int unsigned Q     = 5167;
   localparam int unsigned P     = 757;
   localparam int unsigned HALFQ = (Q - 1) / 2;
   localparam int unsigned NDIG  = (W + 1) / 2;
   localparam int unsigned SHW   = 2 * NDIG;
   localparam int unsigned IDXW  = $clog2(P);
   localparam int unsigned CNTW  = $clog2(NDIG + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCEPT = 3'd1,
      ST_CENTER = 3'd2,
      ST_MOD    = 3'd3,
      ST_ADJ    = 3'd4,
      ST_OUT    = 3'd5,
      ST_DONE   = 3'd6
   } state_t;

   // Centred coefficient held as sign + magnitude between CENTER and ADJ.
   typedef struct packed {
      logic         neg;
      logic [W-1:0] mag;
   } cent_t;

   // One base-4 digit step: 4 == 1 (mod 3), so the residue just accumulates digits.
   function automatic logic [1:0] add_mod3(input logic [1:0] r, input logic [1:0] d);
      logic [2:0] s;
      s = 3'(r) + 3'(d);
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

endpackage

// File: rtl/round_poly_engine_if.sv
// Coefficient input and result output streams of the Round() engine.
interface round_poly_engine_if;
   import round_poly_engine_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_data;
   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_data;
   logic [IDXW-1:0] out_idx;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx
   );
endinterface

// File: rtl/round_poly_engine_mod3_serial.sv
// Digit-serial mod-3 reduction: 2 bits per cycle, MSB first, NDIG cycles after load.
module mod3_serial
   import round_poly_engine_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] din,
   output logic         last_c,
   output logic [1:0]   r
);

   logic [SHW-1:0]  sh;
   logic [CNTW-1:0] cnt;
   logic            run;

   assign last_c = run && (cnt == CNTW'(NDIG - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh  <= '0;
         cnt <= '0;
         run <= 1'b0;
         r   <= 2'd0;
      end else if (load) begin
         sh  <= SHW'(din);
         cnt <= '0;
         run <= 1'b1;
         r   <= 2'd0;
      end else if (run) begin
         r   <= add_mod3(r, sh[SHW-1 -: 2]);
         sh  <= sh << 2;
         cnt <= cnt + CNTW'(1);
         if (last_c) run <= 1'b0;
      end
   end

endmodule

// File: rtl/round_poly_engine.sv
// Streaming Round() unit: centres Fq coefficients and optionally rounds them to a multiple of 3.
module round_poly_engine
   import round_poly_engine_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                mode_round,
   input  logic                clear,
   output logic                busy,
   output logic                done,
   output logic                err_range,
   round_poly_engine_if.slave  bus
);

   state_t          state, state_n;
   logic            mode;
   logic [W-1:0]    coef;
   cent_t           cent;
   cent_t           cent_c;
   logic [IDXW-1:0] idx;
   logic            in_hs_c, out_hs_c;
   logic            mod_load_c, mod_last_c;
   logic [1:0]      mod_r;
   logic            over_c;
   logic [W-1:0]    fixed_c;
   logic [W-1:0]    adj_mag_c;
   logic [W-1:0]    result_c;

   assign in_hs_c     = bus.in_valid & bus.in_ready;
   assign out_hs_c    = bus.out_valid & bus.out_ready;
   assign bus.out_idx = idx;

   mod3_serial u_mod3 (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (mod_load_c),
      .din    (cent_c.mag),
      .last_c (mod_last_c),
      .r      (mod_r)
   );

   // Next-state logic; clear overrides every transition.
   always_comb begin
      state_n    = state;
      mod_load_c = 1'b0;
      case (state)
         ST_IDLE:   if (start) state_n = ST_ACCEPT;
         ST_ACCEPT: if (in_hs_c) state_n = ST_CENTER;
         ST_CENTER: begin
            mod_load_c = 1'b1;
            state_n    = ST_MOD;
         end
         ST_MOD:    if (mod_last_c) state_n = ST_ADJ;
         ST_ADJ:    state_n = ST_OUT;
         ST_OUT:    if (out_hs_c) state_n = (idx == IDXW'(P - 1)) ? ST_DONE : ST_ACCEPT;
         ST_DONE:   state_n = ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
      if (clear) state_n = ST_IDLE;
   end

   // Centre: one conditional subtraction of Q, then fold the upper half to negatives.
   always_comb begin
      over_c  = (coef >= W'(Q));
      fixed_c = over_c ? (coef - W'(Q)) : coef;
      if (fixed_c > W'(HALFQ)) begin
         cent_c.neg = 1'b1;
         cent_c.mag = W'(Q) - fixed_c;
      end else begin
         cent_c.neg = 1'b0;
         cent_c.mag = fixed_c;
      end
   end

   // Adjust magnitude toward the nearest multiple of 3; a zero result is never negated.
   always_comb begin
      adj_mag_c = cent.mag;
      if (mode) begin
         if (mod_r == 2'd1)      adj_mag_c = cent.mag - W'(1);
         else if (mod_r == 2'd2) adj_mag_c = cent.mag + W'(1);
      end
      result_c = (cent.neg && (adj_mag_c != '0)) ? (W'(0) - adj_mag_c) : adj_mag_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         bus.in_ready  <= 1'b0;
         bus.out_valid <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         state         <= state_n;
         bus.in_ready  <= (state_n == ST_ACCEPT);
         bus.out_valid <= (state_n == ST_OUT);
         busy          <= (state_n inside {ST_ACCEPT, ST_CENTER, ST_MOD, ST_ADJ, ST_OUT});
         done          <= (state_n == ST_DONE);
      end
   end

   // Datapath registers and frame bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode         <= 1'b0;
         coef         <= '0;
         cent         <= '0;
         idx          <= '0;
         err_range    <= 1'b0;
         bus.out_data <= '0;
      end else begin
         if ((state == ST_IDLE) && start && !clear) begin
            mode      <= mode_round;
            idx       <= '0;
            err_range <= 1'b0;
         end
         if ((state == ST_ACCEPT) && in_hs_c) coef <= bus.in_data;
         if (state == ST_CENTER) begin
            cent <= cent_c;
            if (over_c) err_range <= 1'b1;
         end
         if (state == ST_ADJ) bus.out_data <= result_c;
         if ((state == ST_OUT) && out_hs_c && (idx != IDXW'(P - 1))) idx <= idx + IDXW'(1);
      end
   end

endmodule

// File: tb/tb_round_poly_engine.sv
// Randomised self-checking bench for round_poly_engine against an arithmetic reference model.
module tb_round_poly_engine;
   import round_poly_engine_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic mode_round = 1'b0;
   logic clear = 1'b0;
   logic busy, done, err_range;

   round_poly_engine_if bus();

   round_poly_engine dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode_round (mode_round),
      .clear      (clear),
      .busy       (busy),
      .done       (done),
      .err_range  (err_range),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] stim [P];
   logic [W-1:0] expv [P];
   logic [W-1:0] got  [P];
   bit           exp_err;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Centre into [-(Q-1)/2,(Q-1)/2] and optionally snap to the nearest multiple of 3.
   function automatic logic [W-1:0] ref_round(input int unsigned c, input bit rnd);
      int v;
      int m;
      v = int'(c);
      if (v >= int'(Q)) v -= int'(Q);
      if (v > int'(HALFQ)) v -= int'(Q);
      if (rnd) begin
         m = ((v % 3) + 3) % 3;
         if (m == 1) v -= 1;
         else if (m == 2) v += 1;
      end
      return W'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input bit rnd, input int ready_pct, input int abort_at, input int glitch_at);
      bit fin;
      bit aborted;
      int acc_cyc;
      exp_err = 1'b0;
      for (int i = 0; i < int'(P); i++) begin
         expv[i] = ref_round(32'(stim[i]), rnd);
         if (32'(stim[i]) >= Q) exp_err = 1'b1;
      end
      tick();
      start = 1'b1;
      mode_round = rnd;
      tick();
      start = 1'b0;
      mode_round = 1'($urandom_range(1));
      check("start_busy", 32'(busy), 1);
      check("start_err_clr", 32'(err_range), 0);
      check("start_idx", 32'(bus.out_idx), 0);
      fin = 1'b0;
      aborted = 1'b0;
      acc_cyc = cyc;
      fork
         begin : drv
            for (int i = 0; i < int'(P) && !fin; i++) begin
               int w;
               bus.in_valid = 1'b1;
               bus.in_data  = stim[i];
               w = 0;
               while (!bus.in_ready && w < 400) begin
                  tick();
                  w++;
               end
               if (w >= 400) begin
                  check("in_ready_timeout", 0, 1);
                  aborted = 1'b1;
                  break;
               end
               tick();
               acc_cyc = cyc;
               bus.in_valid = 1'b0;
               bus.in_data  = W'($urandom);
               if (i == glitch_at) begin
                  start = 1'b1;
                  mode_round = ~rnd;
                  tick();
                  start = 1'b0;
               end
               if (i == abort_at) begin
                  tick();
                  clear = 1'b1;
                  tick();
                  clear = 1'b0;
                  aborted = 1'b1;
                  break;
               end
            end
         end
         begin : mon
            bit prev_v, stalled, hs_prev;
            logic [W-1:0]    hd;
            logic [IDXW-1:0] hi;
            int nout, guard;
            prev_v = 1'b0;
            stalled = 1'b0;
            hs_prev = 1'b0;
            nout = 0;
            guard = 0;
            while (!fin && !aborted && guard < 60000) begin
               tick();
               guard++;
               if (hs_prev) check("drop_after_hs", 32'(bus.out_valid), 0);
               hs_prev = 1'b0;
               if (done) begin
                  check("out_count", 32'(nout), P);
                  check("err_at_done", 32'(err_range), 32'(exp_err));
                  fin = 1'b1;
               end
               if (bus.out_valid) begin
                  if (!prev_v) check("latency", 32'(cyc - acc_cyc), NDIG + 2);
                  if (stalled) begin
                     check("hold_data", 32'(bus.out_data), 32'(hd));
                     check("hold_idx", 32'(bus.out_idx), 32'(hi));
                  end
                  bus.out_ready = ($urandom_range(99) < 32'(ready_pct));
                  if (bus.out_ready) begin
                     if (nout < int'(P)) begin
                        check("data", 32'(bus.out_data), 32'(expv[nout]));
                        got[nout] = bus.out_data;
                     end
                     check("idx", 32'(bus.out_idx), 32'(nout));
                     nout++;
                     stalled = 1'b0;
                     hs_prev = 1'b1;
                  end else begin
                     stalled = 1'b1;
                     hd = bus.out_data;
                     hi = bus.out_idx;
                  end
               end else begin
                  bus.out_ready = 1'($urandom_range(1));
               end
               prev_v = bus.out_valid;
            end
            if (!fin && !aborted) check("frame_timeout", 0, 1);
         end
      join
      bus.out_ready = 1'b0;
      if (fin) begin
         tick();
         check("busy_drop", 32'(busy), 0);
         check("done_once", 32'(done), 0);
      end
   endtask

   logic [W-1:0] tbl1 [8];
   logic [W-1:0] tbl2 [2];

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      tbl1 = '{13'd0, 13'd3, 13'd6, 13'd2583, 13'h15E9, 13'd0, 13'h1FFD, 13'd0};
      tbl2 = '{13'h1FFE, 13'd10};

      repeat (3) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err_range), 0);
      check("rst_in_ready", 32'(bus.in_ready), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_data", 32'(bus.out_data), 0);
      rst_n = 1'b1;

      // Input offered while idle must be ignored.
      bus.in_valid = 1'b1;
      bus.in_data  = 13'd77;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("idle_in_ready", 32'(bus.in_ready), 0);
         check("idle_out_valid", 32'(bus.out_valid), 0);
      end
      bus.in_valid = 1'b0;

      // Rounding, negatives and out-of-range coefficient.
      for (int i = 0; i < int'(P); i++) stim[i] = W'($urandom_range(Q - 1));
      stim[0] = 13'd0;    stim[1] = 13'd4;    stim[2] = 13'd5;    stim[3] = 13'd2583;
      stim[4] = 13'd2584; stim[5] = 13'd5166; stim[6] = 13'd5165; stim[7] = 13'd5167;
      run_frame(1'b1, 100, -1, -1);
      for (int i = 0; i < 8; i++) check("dir_round", 32'(got[i]), 32'(tbl1[i]));

      // Freeze mode; the new start clears the sticky range flag.
      for (int i = 0; i < int'(P); i++) stim[i] = W'($urandom_range(Q - 1));
      stim[0] = 13'd5165;
      stim[1] = 13'd10;
      run_frame(1'b0, 100, -1, -1);
      for (int i = 0; i < 2; i++) check("dir_freeze", 32'(got[i]), 32'(tbl2[i]));

      // Full random frame with heavy backpressure and a stray start mid-frame.
      for (int i = 0; i < int'(P); i++) stim[i] = W'($urandom_range((1 << W) - 1));
      run_frame(1'b1, 30, -1, 50);

      // Abort with clear after coefficient 100.
      for (int i = 0; i < int'(P); i++) stim[i] = W'($urandom_range(Q - 1));
      run_frame(1'b1, 70, 100, -1);
      check("clear_busy", 32'(busy), 0);
      check("clear_in_ready", 32'(bus.in_ready), 0);
      check("clear_out_valid", 32'(bus.out_valid), 0);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("clear_no_done", 32'(done | bus.out_valid), 0);
      end

      // Asynchronous reset while the coefficient sits in the mod-3 stage.
      start = 1'b1;
      mode_round = 1'b1;
      tick();
      start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 13'd5167;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      check("pre_rst_err", 32'(err_range), 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 0);
      check("midrst_err", 32'(err_range), 0);
      check("midrst_out_valid", 32'(bus.out_valid), 0);
      check("midrst_out_data", 32'(bus.out_data), 0);
      check("midrst_idx", 32'(bus.out_idx), 0);
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick();
         check("postrst_quiet", 32'(done | bus.out_valid | busy), 0);
      end

      // Next frame after abort and reset must be fully correct.
      for (int i = 0; i < int'(P); i++) stim[i] = W'($urandom_range((1 << W) - 1));
      run_frame(1'b1, 50, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
